tt_um_coline3003_top: RTL and testbench
=======================================

// Module: tt_um_coline3003_top
// PURPOSE
//  Tiny Tapeout top of the spectrogram extractor. Takes a stream of signed 8-bit audio samples,
//  splits each into 4 octave bands with an undecimated integer Haar filterbank, accumulates
//  per-band |magnitude| over a fixed frame and publishes one 8-bit energy per band per frame.
//  Host reads bands through a select-driven output mux.
// PARAMETERS
//  FRAME_LOG2  6  frame length = 2**FRAME_LOG2 valid samples (64)
//  OUT_SHIFT   8  right shift applied to a frame accumulator before 8-bit saturation
// PORTS
//  clk      in   1  system clock; all state changes on rising edge
//  rst_n    in   1  reset, asynchronous, active-low
//  ena      in   1  tile enable; ignored (design always active)
//  ui_in    in   8  current audio sample x, two's complement
//  uio_in   in   8  [0] sample_valid, [1] clear, [3:2] band_sel, [7:4] unused
//  uo_out   out  8  energy register of band band_sel (combinational mux of registers)
//  uio_out  out  8  [4] frame_done pulse, [5] frame_toggle, all other bits 0
//  uio_oe   out  8  constant 8'b0011_0000
// BEHAVIOUR
//  Reset: history regs, accumulators, sample count, energy regs, frame_done, frame_toggle = 0.
//  Filterbank (signed, full width, no overflow): s1=x+x1, d1=x-x1 (x1=x[n-1], 9b);
//   s2=s1+s1[n-2], d2=s1-s1[n-2] (10b); s3=s2+s2[n-4], d3=s2-s2[n-4] (11b).
//   Band magnitudes: m0=|s3| (low), m1=|d3|, m2=|d2|, m3=|d1| (high); |.| unsigned, |-1024|=1024.
//  On an edge with sample_valid=1 and clear=0:
//   - acc[b] += m[b] (acc width 11+FRAME_LOG2 = 17b, cannot overflow); shift histories; count++.
//   - if count == 2**FRAME_LOG2-1 (last sample): energy[b] <= min(255,(acc[b]+m[b])>>OUT_SHIFT),
//     acc <= 0, count <= 0, frame_done <= 1 for exactly one cycle, frame_toggle flips.
//  Energies visible on uo_out the cycle after the 64th valid edge; held until next frame end.
//  sample_valid=0: no state change except frame_done returning to 0. Gaps between samples allowed.
//  Histories are NOT cleared at frame boundaries (filter continuous across frames); the first frame
//   after reset/clear includes start-up transients from zero history.
//  clear=1 (sync, priority over sample_valid): histories, acc, count <= 0; energy regs and
//   frame_toggle kept; frame_done <= 0.
//  band_sel change updates uo_out combinationally in the same cycle.
//  Async reset mid-frame discards the partial frame; no pulse generated.
// STRUCTURE
//  Package spectro_pkg: SAMPLE_W=8, NUM_BANDS=4, BAND_W=11, FRAME_LOG2, OUT_SHIFT, acc width fn.
//  Sub-module spectro_bandsplit: holds x1, s1 (2 deep), s2 (4 deep) history, outputs m0..m3;
//   top holds accumulators, frame counter, energy regs, saturation, flags and read mux.
// TESTING
//  DC x=10, 128 valid samples -> after 2nd frame: band0=20 (64*80>>8), bands1..3=0; toggle=0.
//  x alternating +64/-64, 128 samples -> 2nd frame: band3=32 (64*128>>8), bands0..2=0.
//  DC x=-128, 128 samples -> 2nd frame band0=255 (65536>>8 saturates); others 0.
//  Frame boundary: frame_done high exactly 1 cycle after 64th valid edge; toggle flips each frame;
//   inserting random sample_valid gaps yields identical energies.
//  clear asserted after 30 samples then 64 DC-10 samples -> frame ends on 64th post-clear sample,
//   energies same as first-frame-from-reset result; old energies held until then.
//  Reset mid-frame (rst_n low 2 cycles) -> uo_out=0 all band_sel, uio_out=0, uio_oe=8'h30.

Source files
------------

// File: rtl/spectro_pkg.sv
// Shared widths, band indices and helpers for the spectrogram extractor.
package spectro_pkg;

  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned NUM_BANDS  = 4;
  localparam int unsigned BAND_W     = 11;
  localparam int unsigned FRAME_LOG2 = 6;
  localparam int unsigned OUT_SHIFT  = 8;

  function automatic int unsigned acc_width(input int unsigned band_w,
                                            input int unsigned frame_log2);
    return band_w + frame_log2;
  endfunction

  typedef enum logic [1:0] {
    BAND_LOW    = 2'd0,
    BAND_MID_LO = 2'd1,
    BAND_MID_HI = 2'd2,
    BAND_HIGH   = 2'd3
  } band_e;

  typedef logic [BAND_W-1:0] mag_t;

endpackage

// File: rtl/spectro_bandsplit.sv
// Undecimated integer Haar filterbank: three cascaded sum/difference stages
// with growing delay spans, producing four unsigned band magnitudes per sample.
module spectro_bandsplit
  import spectro_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              sample_valid,
  input  logic signed [SAMPLE_W-1:0]        x,
  output logic [NUM_BANDS-1:0][BAND_W-1:0]  mag
);

  localparam int unsigned W1 = SAMPLE_W + 1;
  localparam int unsigned W2 = SAMPLE_W + 2;
  localparam int unsigned W3 = SAMPLE_W + 3;

  typedef logic signed [W1-1:0] s1_t;
  typedef logic signed [W2-1:0] s2_t;
  typedef logic signed [W3-1:0] s3_t;

  logic signed [SAMPLE_W-1:0] x1_q, x1_d;
  s1_t s1_hist_q [2];
  s1_t s1_hist_d [2];
  s2_t s2_hist_q [4];
  s2_t s2_hist_d [4];

  s1_t s1, d1;
  s2_t s2, d2;
  s3_t s3, d3;

  always_comb begin
    s1 = s1_t'(x) + s1_t'(x1_q);
    d1 = s1_t'(x) - s1_t'(x1_q);
    s2 = s2_t'(s1) + s2_t'(s1_hist_q[1]);
    d2 = s2_t'(s1) - s2_t'(s1_hist_q[1]);
    s3 = s3_t'(s2) + s3_t'(s2_hist_q[3]);
    d3 = s3_t'(s2) - s3_t'(s2_hist_q[3]);
  end

  // Negating the most negative value wraps to itself, which reads back as the right unsigned magnitude.
  always_comb begin
    mag[0] = s3[W3-1] ? mag_t'(-s3) : mag_t'(s3);
    mag[1] = d3[W3-1] ? mag_t'(-d3) : mag_t'(d3);
    mag[2] = d2[W2-1] ? mag_t'(-d2) : mag_t'(d2);
    mag[3] = d1[W1-1] ? mag_t'(-d1) : mag_t'(d1);
  end

  always_comb begin
    x1_d      = x1_q;
    s1_hist_d = s1_hist_q;
    s2_hist_d = s2_hist_q;
    if (clear) begin
      x1_d      = '0;
      s1_hist_d = '{default: '0};
      s2_hist_d = '{default: '0};
    end else if (sample_valid) begin
      x1_d         = x;
      s1_hist_d[0] = s1;
      s1_hist_d[1] = s1_hist_q[0];
      s2_hist_d[0] = s2;
      for (int unsigned i = 1; i < 4; i++) begin
        s2_hist_d[i] = s2_hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q      <= '0;
      s1_hist_q <= '{default: '0};
      s2_hist_q <= '{default: '0};
    end else begin
      x1_q      <= x1_d;
      s1_hist_q <= s1_hist_d;
      s2_hist_q <= s2_hist_d;
    end
  end

endmodule

// File: rtl/tt_um_coline3003_top.sv
// Tiny Tapeout top: per-band magnitude accumulation over fixed frames,
// saturated 8-bit energy registers and a band-select read mux.
module tt_um_coline3003_top
  import spectro_pkg::*;
#(
  parameter int unsigned FRAME_LOG2 = spectro_pkg::FRAME_LOG2,
  parameter int unsigned OUT_SHIFT  = spectro_pkg::OUT_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned ACC_W = acc_width(BAND_W, FRAME_LOG2);

  logic  sample_valid, clear;
  band_e band_sel;
  logic  unused_ok;

  assign sample_valid = uio_in[0];
  assign clear        = uio_in[1];
  assign band_sel     = band_e'(uio_in[3:2]);
  assign unused_ok    = &{1'b0, ena, uio_in[7:4]};

  logic [NUM_BANDS-1:0][BAND_W-1:0] mag;

  spectro_bandsplit u_bandsplit (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample_valid (sample_valid),
    .x            (ui_in),
    .mag          (mag)
  );

  logic [ACC_W-1:0]      acc_q    [NUM_BANDS];
  logic [ACC_W-1:0]      acc_d    [NUM_BANDS];
  logic [ACC_W-1:0]      acc_sum  [NUM_BANDS];
  logic [ACC_W-1:0]      shifted  [NUM_BANDS];
  logic [7:0]            energy_q [NUM_BANDS];
  logic [7:0]            energy_d [NUM_BANDS];
  logic [FRAME_LOG2-1:0] cnt_q, cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_toggle_q, frame_toggle_d;
  logic                  last_sample;

  assign last_sample = (cnt_q == '1);

  // The closing sample's magnitude is folded in before the shift, so no extra cycle is needed.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANDS; b++) begin
      acc_sum[b] = acc_q[b] + ACC_W'(mag[b]);
      shifted[b] = acc_sum[b] >> OUT_SHIFT;
    end
  end

  always_comb begin
    acc_d          = acc_q;
    energy_d       = energy_q;
    cnt_d          = cnt_q;
    frame_done_d   = 1'b0;
    frame_toggle_d = frame_toggle_q;
    if (clear) begin
      acc_d = '{default: '0};
      cnt_d = '0;
    end else if (sample_valid) begin
      cnt_d = cnt_q + 1'b1;
      for (int unsigned b = 0; b < NUM_BANDS; b++) begin
        acc_d[b] = acc_sum[b];
      end
      if (last_sample) begin
        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
          energy_d[b] = (shifted[b] > ACC_W'(255)) ? 8'hFF : shifted[b][7:0];
          acc_d[b]    = '0;
        end
        cnt_d          = '0;
        frame_done_d   = 1'b1;
        frame_toggle_d = ~frame_toggle_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '{default: '0};
      energy_q       <= '{default: '0};
      cnt_q          <= '0;
      frame_done_q   <= 1'b0;
      frame_toggle_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      energy_q       <= energy_d;
      cnt_q          <= cnt_d;
      frame_done_q   <= frame_done_d;
      frame_toggle_q <= frame_toggle_d;
    end
  end

  assign uo_out  = energy_q[band_sel];
  assign uio_out = {2'b00, frame_toggle_q, frame_done_q, 4'b0000};
  assign uio_oe  = 8'b0011_0000;

endmodule

// File: tb/tb_tt_um_coline3003_top.sv
// Scoreboard bench: windowed-sum Haar reference model predicts each frame's
// energies; a negedge monitor pops and checks whenever frame_done is seen.
module tb_tt_um_coline3003_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic       valid, clr;
  logic [1:0] stim_sel, mon_sel;
  logic       mon_active;
  logic [3:0] junk;
  logic [7:0] uio_in, uo_out, uio_out, uio_oe;

  assign uio_in = {junk, (mon_active ? mon_sel : stim_sel), clr, valid};

  tt_um_coline3003_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0][7:0] e;
    logic            tog;
    logic [31:0]     cyc;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: bands as plain windowed sums over the last 8 samples.
  int              hist [8];
  int              acc_m [4];
  int              cnt_m;
  logic [3:0][7:0] en_m;
  logic            tog_m;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    for (int b = 0; b < 4; b++) acc_m[b] = 0;
    cnt_m = 0;
  endtask

  task automatic model_sample(input int xv);
    int lo4, hi4, m[4], e;
    exp_t ex;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = xv;
    lo4  = hist[0] + hist[1] + hist[2] + hist[3];
    hi4  = hist[4] + hist[5] + hist[6] + hist[7];
    m[0] = iabs(lo4 + hi4);
    m[1] = iabs(lo4 - hi4);
    m[2] = iabs(hist[0] + hist[1] - hist[2] - hist[3]);
    m[3] = iabs(hist[0] - hist[1]);
    for (int b = 0; b < 4; b++) acc_m[b] += m[b];
    cnt_m++;
    if (cnt_m == 64) begin
      for (int b = 0; b < 4; b++) begin
        e = acc_m[b] / 256;
        en_m[b] = (e > 255) ? 8'd255 : 8'(e);
        acc_m[b] = 0;
      end
      cnt_m = 0;
      tog_m = ~tog_m;
      ex.e = en_m;
      ex.tog = tog_m;
      ex.cyc = cyc;
      sb_q.push_back(ex);
    end
  endtask

  // Drives one cycle of inputs; returns 2 time units after the edge.
  task automatic step(input bit v, input logic [7:0] x, input bit c);
    ui_in = x;
    valid = v;
    clr   = c;
    junk  = 4'($urandom);
    @(posedge clk);
    #1;
    if (c) model_clear();
    else if (v) model_sample($signed(x));
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic check_outputs(input string tag);
    for (int b = 0; b < 4; b++) begin
      stim_sel = 2'(b);
      #1;
      check($sformatf("%s band%0d", tag, b), uo_out, en_m[b]);
    end
    check($sformatf("%s uio_out", tag), uio_out & 8'hEF, tog_m ? 8'h20 : 8'h00);
  endtask

  task automatic check_const(input string tag, input int b, input int val);
    stim_sel = 2'(b);
    #1;
    check($sformatf("%s band%0d", tag, b), uo_out, val);
  endtask

  // Monitor: every frame_done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && uio_out[4]) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_done: got unexpected pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("frame_done cycle", cyc, e.cyc);
        check("frame_toggle", uio_out[5], e.tog);
        check("uio_out reserved", uio_out & 8'hCF, 0);
        mon_active = 1'b1;
        for (int b = 0; b < 4; b++) begin
          mon_sel = 2'(b);
          #1;
          check($sformatf("frame energy band%0d", b), uo_out, e.e[b]);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    ui_in = '0; valid = 1'b0; clr = 1'b0; junk = '0;
    stim_sel = '0; mon_sel = '0; mon_active = 1'b0;
    en_m = '0; tog_m = 1'b0;
    model_clear();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_outputs("reset");
    check("reset uio_oe", uio_oe, 8'h30);
    rst_n = 1'b1;

    // DC 10: first frame carries start-up transient, second is steady state.
    repeat (64) step(1'b1, 8'd10, 1'b0);
    check_const("dc10 f1", 0, 18);
    repeat (64) step(1'b1, 8'd10, 1'b0);
    check_const("dc10 f2", 0, 20);
    for (int b = 1; b < 4; b++) check_const("dc10 f2", b, 0);
    check("dc10 toggle", uio_out[5], 0);

    for (int i = 0; i < 128; i++) step(1'b1, (i % 2 == 0) ? 8'h40 : 8'hC0, 1'b0);
    check_const("alt64", 3, 32);
    for (int b = 0; b < 3; b++) check_const("alt64", b, 0);

    repeat (128) step(1'b1, 8'h80, 1'b0);
    check_const("dc-128", 0, 255);
    for (int b = 1; b < 4; b++) check_const("dc-128", b, 0);

    // DC 10 again with random gaps: energies must not depend on timing.
    repeat (128) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      step(1'b1, 8'd10, 1'b0);
    end
    check_const("dc10 gaps", 0, 20);
    check_const("dc10 gaps", 3, 0);

    repeat (384) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      step(1'b1, 8'($urandom), 1'b0);
    end
    check_outputs("random");

    // Clear mid-frame (with valid also high): restart from zero history.
    repeat (30) step(1'b1, 8'($urandom), 1'b0);
    check_outputs("pre clear");
    step(1'b1, 8'($urandom), 1'b1);
    repeat (63) step(1'b1, 8'd10, 1'b0);
    check_outputs("held after clear");
    step(1'b1, 8'd10, 1'b0);
    check_const("post clear", 0, 18);
    for (int b = 1; b < 4; b++) check_const("post clear", b, 0);

    // Asynchronous reset mid-frame.
    repeat (20) step(1'b1, 8'($urandom), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      stim_sel = 2'(b);
      #1;
      check($sformatf("midreset band%0d", b), uo_out, 0);
    end
    check("midreset uio_out", uio_out, 0);
    check("midreset uio_oe", uio_oe, 8'h30);
    en_m = '0;
    tog_m = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    repeat (64) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      step(1'b1, 8'($urandom), 1'b0);
    end
    check_outputs("after reset");

    valid = 1'b0;
    idle(3);
    check("scoreboard drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
